// File: rtl/mem_port_arbiter_40.sv
// mem_port_arbiter_40
// Shares one 32-bit memory port between instruction fetch and load/store.
// One outstanding transaction over a req/ack handshake; data requests win
// unless a fetch has been starved by FAIRNESS consecutive data grants.
// Optional feature macro: MEM_PORT_TIMEOUT_EN (adds a wait-cycle abort that
// pulses err_40 together with the pending ack).
module mem_port_arbiter_40 #(
  parameter int FAIRNESS = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic        clk_40,
  input  logic        rst_40,
  input  logic        if_req_40,
  input  logic [31:0] if_addr_40,
  output logic        if_ack_40,
  output logic [31:0] if_rdata_40,
  input  logic        d_req_40,
  input  logic        d_we_40,
  input  logic [31:0] d_addr_40,
  input  logic [31:0] d_wdata_40,
  output logic        d_ack_40,
  output logic [31:0] d_rdata_40,
  output logic        m_req_40,
  output logic        m_we_40,
  output logic [31:0] m_addr_40,
  output logic [31:0] m_wdata_40,
  input  logic [31:0] m_rdata_40,
  input  logic        m_ack_40,
  output logic        stall_40,
  output logic        err_40
);

  // Elaboration-time range checks on the configuration.
  if (FAIRNESS < 1 || FAIRNESS > 15) begin : g_fairness_range
    $error("mem_port_arbiter_40: FAIRNESS must be within 1..15");
  end
  if (TIMEOUT < 1) begin : g_timeout_range
    $error("mem_port_arbiter_40: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_D_BUSY  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [3:0] FAIR_LIM = 4'(FAIRNESS);

  state_t     state_r;
  logic [3:0] dstreak_r;

`ifdef MEM_PORT_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
  logic [WCW-1:0] wait_cnt_r;
`else
  // Without the timeout feature the error output never fires.
  assign err_40 = 1'b0;
`endif

  // Fetch is stalled whenever it is asking and has not yet been answered.
  assign stall_40 = if_req_40 & ~if_ack_40;

  // Arbitration/handshake FSM with all port-side outputs registered.
  always_ff @(posedge clk_40 or posedge rst_40) begin
    if (rst_40) begin
      state_r     <= ST_IDLE;
      dstreak_r   <= 4'd0;
      m_req_40    <= 1'b0;
      m_we_40     <= 1'b0;
      m_addr_40   <= 32'h0;
      m_wdata_40  <= 32'h0;
      if_ack_40   <= 1'b0;
      if_rdata_40 <= 32'h0;
      d_ack_40    <= 1'b0;
      d_rdata_40  <= 32'h0;
`ifdef MEM_PORT_TIMEOUT_EN
      wait_cnt_r  <= '0;
      err_40      <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if_ack_40 <= 1'b0;
          d_ack_40  <= 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
          err_40     <= 1'b0;
          wait_cnt_r <= '0;
`endif
          if (d_req_40 && (!if_req_40 || (dstreak_r < FAIR_LIM))) begin
            state_r    <= ST_D_BUSY;
            m_req_40   <= 1'b1;
            m_we_40    <= d_we_40;
            m_addr_40  <= d_addr_40;
            m_wdata_40 <= d_wdata_40;
            // Only grants that bypass a waiting fetch count against fairness.
            if (if_req_40 && (dstreak_r != 4'hF)) begin
              dstreak_r <= dstreak_r + 4'd1;
            end else begin
              dstreak_r <= dstreak_r;
            end
          end else if (if_req_40) begin
            state_r    <= ST_IF_BUSY;
            m_req_40   <= 1'b1;
            m_we_40    <= 1'b0;
            m_addr_40  <= if_addr_40;
            m_wdata_40 <= 32'h0;
            dstreak_r  <= 4'd0;
          end else begin
            state_r   <= ST_IDLE;
            dstreak_r <= 4'd0;
          end
        end

        ST_IF_BUSY: begin
          if (m_ack_40) begin
            m_req_40    <= 1'b0;
            if_rdata_40 <= m_rdata_40;
            if_ack_40   <= 1'b1;
            state_r     <= ST_DONE;
`ifdef MEM_PORT_TIMEOUT_EN
          end else if (wait_cnt_r == WAIT_LAST) begin
            m_req_40    <= 1'b0;
            if_rdata_40 <= 32'h0;
            if_ack_40   <= 1'b1;
            err_40      <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            wait_cnt_r  <= wait_cnt_r + 1'b1;
`endif
          end
        end

        ST_D_BUSY: begin
          if (m_ack_40) begin
            m_req_40 <= 1'b0;
            d_ack_40 <= 1'b1;
            state_r  <= ST_DONE;
            // Stores complete without disturbing the last load result.
            if (!m_we_40) begin
              d_rdata_40 <= m_rdata_40;
            end
`ifdef MEM_PORT_TIMEOUT_EN
          end else if (wait_cnt_r == WAIT_LAST) begin
            m_req_40 <= 1'b0;
            d_ack_40 <= 1'b1;
            err_40   <= 1'b1;
            state_r  <= ST_DONE;
            if (!m_we_40) begin
              d_rdata_40 <= 32'h0;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
`endif
          end
        end

        ST_DONE: begin
          // Ack lives for this cycle only; always revisit IDLE so a stale
          // request is never granted twice.
          if_ack_40 <= 1'b0;
          d_ack_40  <= 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
          err_40    <= 1'b0;
`endif
          state_r   <= ST_IDLE;
        end

        default: begin
          state_r   <= ST_IDLE;
          m_req_40  <= 1'b0;
          if_ack_40 <= 1'b0;
          d_ack_40  <= 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
          err_40    <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter_40.sv
// Directed self-checking bench for mem_port_arbiter_40.
// Inputs change 1ns after a rising edge; outputs are sampled at that point.
module tb_mem_port_arbiter_40;

  logic        clk_40 = 1'b0;
  logic        rst_40 = 1'b0;
  logic        if_req_40 = 1'b0;
  logic [31:0] if_addr_40 = 32'h0;
  logic        if_ack_40;
  logic [31:0] if_rdata_40;
  logic        d_req_40 = 1'b0;
  logic        d_we_40 = 1'b0;
  logic [31:0] d_addr_40 = 32'h0;
  logic [31:0] d_wdata_40 = 32'h0;
  logic        d_ack_40;
  logic [31:0] d_rdata_40;
  logic        m_req_40;
  logic        m_we_40;
  logic [31:0] m_addr_40;
  logic [31:0] m_wdata_40;
  logic [31:0] m_rdata_40 = 32'h0;
  logic        m_ack_40 = 1'b0;
  logic        stall_40;
  logic        err_40;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef MEM_PORT_TIMEOUT_EN
  mem_port_arbiter_40 #(.FAIRNESS(4), .TIMEOUT(8)) dut (
`else
  mem_port_arbiter_40 #(.FAIRNESS(4)) dut (
`endif
    .clk_40(clk_40), .rst_40(rst_40),
    .if_req_40(if_req_40), .if_addr_40(if_addr_40),
    .if_ack_40(if_ack_40), .if_rdata_40(if_rdata_40),
    .d_req_40(d_req_40), .d_we_40(d_we_40), .d_addr_40(d_addr_40),
    .d_wdata_40(d_wdata_40), .d_ack_40(d_ack_40), .d_rdata_40(d_rdata_40),
    .m_req_40(m_req_40), .m_we_40(m_we_40), .m_addr_40(m_addr_40),
    .m_wdata_40(m_wdata_40), .m_rdata_40(m_rdata_40), .m_ack_40(m_ack_40),
    .stall_40(stall_40), .err_40(err_40)
  );

  always #5 clk_40 = ~clk_40;

  task automatic tick();
    @(posedge clk_40);
    #1;
  endtask

  task automatic test_reset();
    rst_40 = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({m_req_40, m_we_40, if_ack_40, d_ack_40, err_40, stall_40} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {m_req_40, m_we_40, if_ack_40, d_ack_40, err_40, stall_40});
    end
    tests_run++;
    if ({m_addr_40, m_wdata_40, if_rdata_40, d_rdata_40} !== 128'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h %h %h %h want all 0",
               m_addr_40, m_wdata_40, if_rdata_40, d_rdata_40);
    end
    #2 rst_40 = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    if_req_40 = 1'b1;
    if_addr_40 = 32'h100;
    tick();
    tests_run++;
    if ({m_req_40, m_we_40, if_ack_40, stall_40} !== 4'b1001 || m_addr_40 !== 32'h100) begin
      tests_failed++;
      $display("FAIL fetch_grant: got req/we/ack/stall=%b addr=%h want 1001 addr=100",
               {m_req_40, m_we_40, if_ack_40, stall_40}, m_addr_40);
    end
    m_ack_40 = 1'b1;
    m_rdata_40 = 32'hDEADBEEF;
    tick();
    tests_run++;
    if ({if_ack_40, m_req_40, stall_40} !== 3'b100 || if_rdata_40 !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL fetch_ack: got ack/mreq/stall=%b rdata=%h want 100 rdata=deadbeef",
               {if_ack_40, m_req_40, stall_40}, if_rdata_40);
    end
    m_ack_40 = 1'b0;
    if_req_40 = 1'b0;
    tick();
    tests_run++;
    if ({if_ack_40, stall_40, m_req_40} !== 3'b000) begin
      tests_failed++;
      $display("FAIL fetch_after: got ack/stall/mreq=%b want 000",
               {if_ack_40, stall_40, m_req_40});
    end
  endtask

  task automatic test_stray_ack();
    m_ack_40 = 1'b1;
    m_rdata_40 = 32'hAAAA5555;
    tick();
    m_ack_40 = 1'b0;
    tests_run++;
    if ({if_ack_40, d_ack_40, m_req_40} !== 3'b000 || if_rdata_40 !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL stray_ack: got acks/mreq=%b if_rdata=%h want 000 deadbeef",
               {if_ack_40, d_ack_40, m_req_40}, if_rdata_40);
    end
  endtask

  task automatic test_store();
    d_req_40 = 1'b1;
    d_we_40 = 1'b1;
    d_addr_40 = 32'h200;
    d_wdata_40 = 32'h12345678;
    m_rdata_40 = 32'h55555555;
    for (int c = 1; c <= 3; c++) begin
      tick();
      tests_run++;
      if ({m_req_40, m_we_40, d_ack_40} !== 3'b110 || m_addr_40 !== 32'h200 ||
          m_wdata_40 !== 32'h12345678) begin
        tests_failed++;
        $display("FAIL store_hold%0d: got req/we/ack=%b addr=%h wdata=%h want 110 200 12345678",
                 c, {m_req_40, m_we_40, d_ack_40}, m_addr_40, m_wdata_40);
      end
    end
    m_ack_40 = 1'b1;
    tick();
    tests_run++;
    if ({d_ack_40, m_req_40} !== 2'b10 || d_rdata_40 !== 32'h0) begin
      tests_failed++;
      $display("FAIL store_ack: got ack/mreq=%b d_rdata=%h want 10 00000000",
               {d_ack_40, m_req_40}, d_rdata_40);
    end
    m_ack_40 = 1'b0;
    d_req_40 = 1'b0;
    d_we_40 = 1'b0;
    tick();
    tests_run++;
    if (d_ack_40 !== 1'b0) begin
      tests_failed++;
      $display("FAIL store_pulse: got d_ack=%b want 0", d_ack_40);
    end
  endtask

  task automatic test_load();
    d_req_40 = 1'b1;
    d_addr_40 = 32'h300;
    tick();
    tests_run++;
    if ({m_req_40, m_we_40} !== 2'b10 || m_addr_40 !== 32'h300) begin
      tests_failed++;
      $display("FAIL load_grant: got req/we=%b addr=%h want 10 300",
               {m_req_40, m_we_40}, m_addr_40);
    end
    m_ack_40 = 1'b1;
    m_rdata_40 = 32'hCAFEF00D;
    tick();
    tests_run++;
    if (d_ack_40 !== 1'b1 || d_rdata_40 !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("FAIL load_ack: got ack=%b d_rdata=%h want 1 cafef00d", d_ack_40, d_rdata_40);
    end
    m_ack_40 = 1'b0;
    d_req_40 = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic exp_fetch;
    logic got_fetch;
    if_req_40 = 1'b1;
    if_addr_40 = 32'h1000;
    d_req_40 = 1'b1;
    d_we_40 = 1'b0;
    d_addr_40 = 32'h2000;
    for (int g = 0; g < 10; g++) begin
      exp_fetch = (g == 4) || (g == 9);
      tick();
      got_fetch = (m_addr_40 == 32'h1000);
      tests_run++;
      if (m_req_40 !== 1'b1 || got_fetch !== exp_fetch || stall_40 !== 1'b1) begin
        tests_failed++;
        $display("FAIL contention_grant%0d: got req=%b fetch=%b stall=%b want 1 %b 1",
                 g, m_req_40, got_fetch, stall_40, exp_fetch);
      end
      m_ack_40 = 1'b1;
      m_rdata_40 = 32'h10000000 + 32'(g);
      tick();
      m_ack_40 = 1'b0;
      tests_run++;
      if ({if_ack_40, d_ack_40} !== {exp_fetch, ~exp_fetch}) begin
        tests_failed++;
        $display("FAIL contention_ack%0d: got if/d ack=%b%b want %b%b",
                 g, if_ack_40, d_ack_40, exp_fetch, ~exp_fetch);
      end
      tick();
    end
    if_req_40 = 1'b0;
    d_req_40 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    d_req_40 = 1'b1;
    d_addr_40 = 32'h400;
    tick();
    tests_run++;
    if (m_req_40 !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_grant: got m_req=%b want 1", m_req_40);
    end
    #2 rst_40 = 1'b1;
    #1;
    tests_run++;
    if (m_req_40 !== 1'b0 || d_ack_40 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_async: got m_req=%b d_ack=%b want 0 0", m_req_40, d_ack_40);
    end
    m_ack_40 = 1'b1;
    tick();
    m_ack_40 = 1'b0;
    if_req_40 = 1'b1;
    if_addr_40 = 32'h100;
    #2 rst_40 = 1'b0;
    tick();
    tests_run++;
    if (m_req_40 !== 1'b1 || m_addr_40 !== 32'h400 || d_ack_40 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_regrant: got m_req=%b addr=%h d_ack=%b want 1 400 0",
               m_req_40, m_addr_40, d_ack_40);
    end
    m_ack_40 = 1'b1;
    tick();
    m_ack_40 = 1'b0;
    d_req_40 = 1'b0;
    if_req_40 = 1'b0;
    tick();
    tick();
  endtask

`ifdef MEM_PORT_TIMEOUT_EN
  task automatic test_timeout();
    if_req_40 = 1'b1;
    if_addr_40 = 32'h500;
    tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      tests_run++;
      if (err_40 !== (k == 8) || if_ack_40 !== (k == 8)) begin
        tests_failed++;
        $display("FAIL timeout_cyc%0d: got err=%b ack=%b want %b", k, err_40, if_ack_40, (k == 8));
      end
    end
    tests_run++;
    if (if_rdata_40 !== 32'h0 || m_req_40 !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_data: got rdata=%h m_req=%b want 0 0", if_rdata_40, m_req_40);
    end
    if_req_40 = 1'b0;
    tick();
    if_req_40 = 1'b1;
    if_addr_40 = 32'h600;
    tick();
    m_ack_40 = 1'b1;
    m_rdata_40 = 32'h600D600D;
    tick();
    m_ack_40 = 1'b0;
    if_req_40 = 1'b0;
    tests_run++;
    if (if_ack_40 !== 1'b1 || err_40 !== 1'b0 || if_rdata_40 !== 32'h600D600D) begin
      tests_failed++;
      $display("FAIL timeout_recover: got ack=%b err=%b rdata=%h want 1 0 600d600d",
               if_ack_40, err_40, if_rdata_40);
    end
    tick();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_stray_ack();
    test_store();
    test_load();
    test_contention();
    test_reset_mid();
`ifdef MEM_PORT_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
